// File: rtl/data_ram_responder.sv
// Data RAM responder for the execute stage's data port.
// Holds a word array of 2**ADDR_W 32-bit entries.
// Writes commit per byte lane on the accepting edge and produce no response.
// Reads return the full word after READ_LATENCY edges, signalled by a one-cycle r_valid strobe.
//
// Handshake: a request (data_ram_en=1) is taken on a rising edge only while
// data_ram_ready=1; otherwise it is ignored and the initiator keeps presenting it.
// data_ram_ready drops only while a multi-cycle read is outstanding, so at most
// one read is in flight. data_ram_r_valid is high for exactly the one cycle in
// which data_ram_r_data carries the response; r_data holds its value afterwards.
module data_ram_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ram_en,
  input  logic [31:0] data_ram_addr,
  input  logic [3:0]  data_ram_w_en,
  input  logic [31:0] data_ram_w_data,
  output logic        data_ram_ready,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_r_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter preload for the WAIT phase; unused when READ_LATENCY=1.
  localparam logic [1:0] CNT_LOAD = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_ram_responder: READ_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [31:0]       hold_q;
  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] idx;
  logic              rd_accept;
  logic              wr_accept;
  logic              unused_addr_bits;

  // Upper address bits alias onto the array; byte offset is the MEM stage's concern.
  assign idx              = data_ram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_ram_addr[31:ADDR_W+2], data_ram_addr[1:0]};

  assign data_ram_ready   = (state != WAIT);
  assign data_ram_r_valid = (state == RESP);

  // A request is a read when no byte lane is enabled.
  assign rd_accept = data_ram_en && data_ram_ready && (data_ram_w_en == 4'b0000);
  assign wr_accept = data_ram_en && data_ram_ready && (data_ram_w_en != 4'b0000);

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: reads go to RESP directly or through WAIT; writes never wait.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (rd_accept) begin
          state_nxt = (READ_LATENCY == 1) ? RESP : WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Read path: capture the word at accept, publish it on the edge entering RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q          <= 32'd0;
      data_ram_r_data <= 32'd0;
    end else begin
      if (rd_accept) begin
        hold_q <= mem[idx];
        if (READ_LATENCY == 1) begin
          data_ram_r_data <= mem[idx];
        end
      end else if (state == WAIT && cnt == 2'd0) begin
        data_ram_r_data <= hold_q;
      end
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (data_ram_w_en[i]) begin
          mem[idx][8*i +: 8] <= data_ram_w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: three instances (READ_LATENCY 1, 3, 4) share
// clock and reset, each with its own request stream. A transaction-level model
// predicts ready / r_valid / r_data from accept edges and response edge numbers.
module tb_data_ram_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 1024;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       en    = '0;
  logic [NDUT-1:0][31:0] addr  = '0;
  logic [NDUT-1:0][3:0]  w_en  = '0;
  logic [NDUT-1:0][31:0] wdata = '0;
  logic [NDUT-1:0]       rdy;
  logic [NDUT-1:0][31:0] rdata;
  logic [NDUT-1:0]       rvalid;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_ram_responder #(
      .ADDR_W(10),
      .READ_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .data_ram_en     (en[g]),
      .data_ram_addr   (addr[g]),
      .data_ram_w_en   (w_en[g]),
      .data_ram_w_data (wdata[g]),
      .data_ram_ready  (rdy[g]),
      .data_ram_r_data (rdata[g]),
      .data_ram_r_valid(rvalid[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [NDUT][DEPTH];
  int          edge_n = 0;
  bit          pend      [NDUT] = '{0, 0, 0};
  int          resp_at   [NDUT] = '{0, 0, 0};
  logic [31:0] pend_data [NDUT];
  bit          exp_ready [NDUT] = '{1, 1, 1};
  bit          exp_rvalid[NDUT] = '{0, 0, 0};
  logic [31:0] exp_rdata [NDUT] = '{0, 0, 0};

  // Each read accepted at edge t is answered at edge t+LAT-1; ready is low
  // strictly between accept and answer.
  always @(posedge clk or negedge reset) begin
    bit rv;
    int idx;
    if (!reset) begin
      for (int k = 0; k < NDUT; k++) begin
        pend[k]       = 0;
        exp_ready[k]  = 1;
        exp_rvalid[k] = 0;
        exp_rdata[k]  = 32'd0;
      end
    end else begin
      edge_n++;
      for (int k = 0; k < NDUT; k++) begin
        rv = 0;
        if (pend[k] && resp_at[k] == edge_n) begin
          rv           = 1;
          exp_rdata[k] = pend_data[k];
          pend[k]      = 0;
        end
        if (en[k] && exp_ready[k]) begin
          idx = int'((addr[k] >> 2) % DEPTH);
          if (w_en[k] == 4'b0000) begin
            if (lat_of(k) == 1) begin
              rv           = 1;
              exp_rdata[k] = mm[k][idx];
            end else begin
              pend[k]      = 1;
              resp_at[k]   = edge_n + lat_of(k) - 1;
              pend_data[k] = mm[k][idx];
            end
          end else begin
            for (int i = 0; i < 4; i++)
              if (w_en[k][i]) mm[k][idx][8*i +: 8] = wdata[k][8*i +: 8];
          end
        end
        exp_rvalid[k] = rv;
        exp_ready[k]  = !pend[k];
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        chk($sformatf("dut%0d_ready", k), 32'(rdy[k]), 32'(exp_ready[k]));
        chk($sformatf("dut%0d_r_valid", k), 32'(rvalid[k]), 32'(exp_rvalid[k]));
        chk($sformatf("dut%0d_r_data", k), rdata[k], exp_rdata[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic e, input logic [31:0] a,
                         input logic [3:0] we, input logic [31:0] d);
    en[k]    = e;
    addr[k]  = a;
    w_en[k]  = we;
    wdata[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) set_req(k, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic wr1(input int k, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    set_req(k, 1'b1, a, we, d);
    cyc();
    set_req(k, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    @(posedge clk);
    #1;
    chk_en = 1;
    cyc();
    cyc();
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_ready", 32'(rdy[k]), 32'd1);
      chk("reset_r_valid", 32'(rvalid[k]), 32'd0);
      chk("reset_r_data", rdata[k], 32'd0);
    end
    reset = 1'b1;
    cyc();

    // Give every word the bench will read a defined value.
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < NDUT; k++) set_req(k, 1'b1, 32'(w * 4), 4'hF, $urandom);
      cyc();
    end
    idle_all();
    cyc();

    // Latency 1: write then read.
    wr1(0, 32'h10, 4'hF, 32'hDEADBEEF);
    set_req(0, 1'b1, 32'h10, 4'h0, 32'd0);
    cyc();
    chk("l1_read_valid", 32'(rvalid[0]), 32'd1);
    chk("l1_read_data", rdata[0], 32'hDEADBEEF);
    set_req(0, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();

    // Byte-lane merges.
    wr1(0, 32'h20, 4'hF, 32'h11223344);
    wr1(0, 32'h20, 4'b0100, 32'h00AA0000);
    set_req(0, 1'b1, 32'h20, 4'h0, 32'd0);
    cyc();
    chk("lane_merge_1", rdata[0], 32'h11AA3344);
    wr1(0, 32'h20, 4'b1100, 32'hBEEF0000);
    set_req(0, 1'b1, 32'h20, 4'h0, 32'd0);
    cyc();
    chk("lane_merge_2", rdata[0], 32'hBEEF3344);
    set_req(0, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();

    // Back-to-back reads at latency 1.
    wr1(0, 32'h0, 4'hF, 32'd1);
    wr1(0, 32'h4, 4'hF, 32'd2);
    wr1(0, 32'h8, 4'hF, 32'd3);
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 32'(i * 4), 4'h0, 32'd0);
      cyc();
      chk("b2b_valid", 32'(rvalid[0]), 32'd1);
      chk("b2b_data", rdata[0], 32'(i + 1));
    end
    set_req(0, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();
    chk("b2b_end_valid", 32'(rvalid[0]), 32'd0);
    chk("b2b_hold_data", rdata[0], 32'd3);

    // Address aliasing and ignored byte offset.
    wr1(0, 32'h00001004, 4'hF, 32'h5A5A5A5A);
    set_req(0, 1'b1, 32'h00000004, 4'h0, 32'd0);
    cyc();
    chk("alias_read", rdata[0], 32'h5A5A5A5A);
    set_req(0, 1'b1, 32'h00000007, 4'h0, 32'd0);
    cyc();
    chk("offset_read", rdata[0], 32'h5A5A5A5A);
    set_req(0, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();

    // Latency 3 with a second request held through WAIT.
    wr1(1, 32'h20, 4'hF, 32'hCAFE0003);
    wr1(1, 32'h24, 4'hF, 32'h0BAD0024);
    set_req(1, 1'b1, 32'h20, 4'h0, 32'd0);
    cyc();
    chk("l3_ready_t", 32'(rdy[1]), 32'd0);
    set_req(1, 1'b1, 32'h24, 4'h0, 32'd0);
    cyc();
    chk("l3_ready_t1", 32'(rdy[1]), 32'd0);
    chk("l3_valid_t1", 32'(rvalid[1]), 32'd0);
    cyc();
    chk("l3_ready_t2", 32'(rdy[1]), 32'd1);
    chk("l3_valid_t2", 32'(rvalid[1]), 32'd1);
    chk("l3_data_t2", rdata[1], 32'hCAFE0003);
    cyc();
    chk("l3_second_accept", 32'(rdy[1]), 32'd0);
    chk("l3_valid_t3", 32'(rvalid[1]), 32'd0);
    set_req(1, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();
    cyc();
    chk("l3_second_valid", 32'(rvalid[1]), 32'd1);
    chk("l3_second_data", rdata[1], 32'h0BAD0024);
    cyc();

    // Latency 4, reset two cycles after accept drops the read.
    wr1(2, 32'h30, 4'hF, 32'h600DF00D);
    set_req(2, 1'b1, 32'h30, 4'h0, 32'd0);
    cyc();
    set_req(2, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_drop_valid", 32'(rvalid[2]), 32'd0);
      chk("rst_drop_data", rdata[2], 32'd0);
    end
    set_req(2, 1'b1, 32'h30, 4'h0, 32'd0);
    cyc();
    set_req(2, 1'b0, 32'd0, 4'd0, 32'd0);
    cyc();
    cyc();
    cyc();
    chk("l4_after_rst_valid", 32'(rvalid[2]), 32'd1);
    chk("l4_after_rst_data", rdata[2], 32'h600DF00D);
    cyc();

    // Randomized traffic on all three instances.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        logic [31:0] a;
        logic [3:0]  we;
        a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        set_req(k, ($urandom_range(0, 3) != 0), a, we, $urandom);
      end
      cyc();
    end
    idle_all();
    for (int i = 0; i < 6; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the data RAM port driven by the execute stage: accepts requests on data_ram_en/addr/w_en/w_data.
- Reads are served from an internal word array after a configurable latency, with a one-cycle response strobe to the memory-access stage.
- Writes are committed per byte lane using the lane-aligned write data.
- Holds the single-outstanding-read handshake that lets the pipeline tolerate multi-cycle data memory.

Parameters:
ADDR_W, 10, word-address width; array depth = 2**ADDR_W words of 32 bits
READ_LATENCY, 1, edges from accepting edge to response; legal 1..4; other values are a elaboration error

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
data_ram_en  input  1  request valid
data_ram_addr  input  32  byte address; word index = addr[ADDR_W+1:2]
data_ram_w_en  input  4  byte-lane write enables; 0000 with en=1 means read
data_ram_w_data  input  32  lane-aligned write data (lane i = bits 8i+7:8i)
data_ram_ready  output  1  request accepted on this edge if data_ram_en=1
data_ram_r_data  output  32  full read word; MEM stage selects and extends bytes
data_ram_r_valid  output  1  one-cycle strobe, r_data valid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, latency counter=0, data_ram_r_valid=0, data_ram_r_data=0, data_ram_ready=1 on deassertion. Array contents are not cleared and are undefined at power-up.
- Reset mid-read: the outstanding read is dropped and no r_valid is produced. Writes already committed remain.
- Acceptance: a request is accepted on a rising edge where data_ram_en=1 and data_ram_ready=1.
  - With data_ram_ready=0 the request is ignored with no side effects; the initiator holds it.
- States:
  - IDLE: ready=1, r_valid=0.
  - WAIT: ready=0; counter loaded with READ_LATENCY-2 on accept and decremented each edge.
  - RESP: ready=1, r_valid=1 for exactly one cycle.
- Transitions:
  - IDLE/RESP + accepted read, READ_LATENCY=1 -> RESP.
  - IDLE/RESP + accepted read, READ_LATENCY>1 -> WAIT.
  - WAIT with counter=0 -> RESP.
  - RESP with no accepted read -> IDLE.
  - Accepted write leaves IDLE->IDLE and RESP->IDLE. Writes never enter WAIT.
- Read timing:
  - Word captured at the accepting edge into a holding register (read-first: a write in the same edge is impossible because reads and writes are exclusive per request).
  - data_ram_r_data updates on the edge that enters RESP. r_valid is high in the cycle after edge t+READ_LATENCY-1, where t is the accepting edge.
- Back-to-back: with READ_LATENCY=1, one read per cycle is sustained and r_valid stays high continuously. A read or write may be accepted during RESP.
- Write:
  - At the accepting edge, mem[idx] lane i <- w_data lane i for each w_en[i]=1. Other lanes are unchanged.
  - No response strobe; r_valid and r_data are unaffected.
- Read-after-write to the same word on consecutive edges returns the new merged value; no bypass path is needed since the write commits first.
- Address bits above ADDR_W+1 are ignored (aliasing wrap). addr[1:0] are ignored by the responder.
- data_ram_r_data holds its last value when r_valid=0.

Test Plan:
- Reset, READ_LATENCY=1: write w_en=1111 addr 0x10 data 0xDEADBEEF, then read 0x10 -> next cycle r_valid=1, r_data=0xDEADBEEF. Earlier reset asserted -> r_valid=0, r_data=0, ready=1.
- Byte lanes: word 0x20 = 0x11223344, then write w_en=0100 data 0x00AA0000 -> read returns 0x11AA3344. Then w_en=1100 data 0xBEEF0000 -> read returns 0xBEEF3344.
- READ_LATENCY=3: read accepted at edge t -> ready=0 after edge t until edge t+2 enters RESP; r_valid high only in the cycle after edge t+2. A second en=1 held during WAIT is accepted at edge t+3.
- Back-to-back, READ_LATENCY=1: reads of 0x0, 0x4, 0x8 holding 1, 2, 3 on consecutive edges -> r_valid high three consecutive cycles with r_data 1, 2, 3.
- Aliasing, ADDR_W=10: write 0x00001004 data 0x5A5A5A5A -> read 0x00000004 returns 0x5A5A5A5A. Read with addr[1:0]=2'b11 returns the same full word.
- Reset mid-read, READ_LATENCY=4: assert reset 2 cycles after accept -> no r_valid ever appears, r_data=0. After release, a read of the previously written word returns the original data.
